led_pattern_ctrl: RTL and testbench
===================================

// Module: led_pattern_ctrl
// PURPOSE
//  Bus-mapped, N-channel LED pattern generator driving the board LED pins (PIN_LED).
//  Generalises the single LED blink path to NCHAN channels, each OFF/ON/BLINK/PWM.
//  A shared prescaler sets the timebase; registers sit on the MCU peripheral bus.
//  Firmware sets patterns once; hardware then runs them with no CPU load.
// PARAMETERS
//  NCHAN    8   number of LED channels (1..8)
//  PRE_W   16   prescaler width; tick period = PRESCALE+1 clocks
//  CNT_W    8   per-channel period/duty counter width (<=8)
//  ADDR_W   5   register address width; must cover 2+2*NCHAN registers
// PORTS
//  CLK     in   1       system clock; all logic on rising edge
//  RESET   in   1       synchronous, active-high reset
//  ADDR    in   ADDR_W  register address
//  DIN     in   16      write data
//  WR      in   1       write strobe, one cycle per write
//  RD      in   1       read strobe
//  DOUT    out  16      read data, valid the cycle after RD
//  TICK    out  1       prescaler tick pulse (debug/test)
//  LED     out  NCHAN   registered LED drive, 1 = lit
// BEHAVIOUR
//  Reset: LED=0, DOUT=0, TICK=0, PRESCALE=0, EN=0, all modes OFF, all counters/phases 0.
//  RESET asserted mid-pattern wins over WR and tick in the same cycle.
//  Register map: 0 PRESCALE[PRE_W-1:0]; 1 CTRL: [0] EN, [1] RESTART (write-only,
//   self-clearing, reads 0); 2+2c CFG_c: [1:0] MODE, [15:8] PERIOD;
//   3+2c DUTY_c: [CNT_W-1:0]. Unused bits read 0; unmapped addresses read 0, writes ignored.
//  Reads: DOUT registered, 1-cycle latency; DOUT holds its last value when RD=0.
//  Prescaler: pcnt counts 0..PRESCALE while EN=1; TICK=1 for one cycle when pcnt==PRESCALE,
//   then pcnt wraps to 0. EN=0 holds pcnt at 0, TICK=0, LEDs frozen at current value.
//  PRESCALE=0 -> TICK every cycle while EN=1.
//  Per channel, counter cnt_c and phase bit ph_c advance only on TICK:
//   MODE 0 OFF: LED=0. MODE 1 ON: LED=1 (independent of EN and TICK).
//   MODE 2 BLINK: cnt 0..PERIOD; at cnt==PERIOD wrap and toggle ph; LED=ph.
//    Half-period = PERIOD+1 ticks.
//   MODE 3 PWM: cnt 0..PERIOD wrapping; LED=(cnt<DUTY). DUTY=0 -> always 0;
//    DUTY>PERIOD -> always 1.
//  LED updates on the clock edge after the TICK cycle (one register stage).
//  Write to CFG_c or DUTY_c: cnt_c=0, ph_c=0 on the next edge. Other channels are undisturbed.
//  RESTART: pcnt and every cnt/ph cleared on the next edge; channels re-phase in lockstep.
//  Write coinciding with TICK: write wins for the affected channel; other channels still advance.
//  Writing PRESCALE clears pcnt. Counter arithmetic is unsigned CNT_W bits.
//  PERIOD bits above CNT_W are ignored.
// TESTING
//  Reset 2 cycles, release -> LED=0, DOUT=0 on RD of addr 0/1/2; TICK never asserts.
//  PRESCALE=3, EN=1 -> TICK high 1 cycle in every 4; EN=0 -> TICK stays 0.
//  PRESCALE=0, EN=1, CFG_0={PERIOD=2,MODE=2} -> LED[0] toggles every 3 cycles: 0,0,0,1,1,1,0...
//  CFG_1={PERIOD=3,MODE=3}, DUTY_1=1 / 0 / 5, PRESCALE=0 -> LED[1] duty 1/4, then 0, then 1.
//  Two BLINK channels, different write times, then RESTART -> both LEDs edge on the same cycle.
//  RESET mid-PWM with simultaneous WR -> all outputs 0 next edge; write discarded; readback 0.

Source files
------------

// File: rtl/led_pattern_ctrl.sv
// N-channel LED pattern generator on the MCU peripheral bus.
// Ports: i_clk, i_reset (sync, high), i_addr/i_din/i_wr/i_rd bus, o_dout, o_tick, o_led.
module led_pattern_ctrl #(
    parameter int NCHAN  = 8,
    parameter int PRE_W  = 16,
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 5
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [15:0]       i_din,
    input  logic              i_wr,
    input  logic              i_rd,
    output logic [15:0]       o_dout,
    output logic              o_tick,
    output logic [NCHAN-1:0]  o_led
);

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_PWM   = 2'd3;

    logic [PRE_W-1:0] r_prescale;
    logic [PRE_W-1:0] r_pcnt;
    logic             r_en;
    logic [1:0]       r_mode [NCHAN];
    logic [CNT_W-1:0] r_per  [NCHAN];
    logic [CNT_W-1:0] r_duty [NCHAN];
    logic [CNT_W-1:0] r_cnt  [NCHAN];
    logic [NCHAN-1:0] r_ph;
    logic [NCHAN-1:0] r_led;
    logic [15:0]      r_dout;

    logic             w_wr_pre;
    logic             w_wr_ctrl;
    logic             w_restart;
    logic             w_tick;
    logic [NCHAN-1:0] w_cfg_wr;
    logic [NCHAN-1:0] w_duty_wr;
    logic [1:0]       w_mode_nxt [NCHAN];
    logic [CNT_W-1:0] w_per_nxt  [NCHAN];
    logic [CNT_W-1:0] w_duty_nxt [NCHAN];
    logic [CNT_W-1:0] w_cnt_nxt  [NCHAN];
    logic [NCHAN-1:0] w_ph_nxt;
    logic [NCHAN-1:0] w_led_nxt;
    logic [15:0]      w_rdata;

    assign w_wr_pre  = i_wr && (i_addr == ADDR_W'(0));
    assign w_wr_ctrl = i_wr && (i_addr == ADDR_W'(1));
    assign w_restart = w_wr_ctrl && i_din[1];
    assign w_tick    = r_en && (r_pcnt == r_prescale);

    // Channel next state. The LED register is loaded from the next-state
    // counter/phase so it moves on the edge that ends the tick cycle.
    always_comb begin
        w_cfg_wr  = '0;
        w_duty_wr = '0;
        w_ph_nxt  = r_ph;
        w_led_nxt = '0;
        for (int c = 0; c < NCHAN; c++) begin
            w_cfg_wr[c]  = i_wr && (i_addr == ADDR_W'(2 + 2 * c));
            w_duty_wr[c] = i_wr && (i_addr == ADDR_W'(3 + 2 * c));
            w_mode_nxt[c] = w_cfg_wr[c] ? i_din[1:0] : r_mode[c];
            w_per_nxt[c]  = w_cfg_wr[c] ? i_din[8 +: CNT_W] : r_per[c];
            w_duty_nxt[c] = w_duty_wr[c] ? i_din[CNT_W-1:0] : r_duty[c];
            w_cnt_nxt[c]  = r_cnt[c];
            if (w_cfg_wr[c] || w_duty_wr[c] || w_restart) begin
                w_cnt_nxt[c] = '0;
                w_ph_nxt[c]  = 1'b0;
            end else if (w_tick && r_mode[c][1]) begin
                if (r_cnt[c] == r_per[c]) begin
                    w_cnt_nxt[c] = '0;
                    if (r_mode[c] == MODE_BLINK)
                        w_ph_nxt[c] = ~r_ph[c];
                end else begin
                    w_cnt_nxt[c] = r_cnt[c] + CNT_W'(1);
                end
            end
            case (w_mode_nxt[c])
                MODE_OFF:   w_led_nxt[c] = 1'b0;
                MODE_ON:    w_led_nxt[c] = 1'b1;
                MODE_BLINK: w_led_nxt[c] = w_ph_nxt[c];
                MODE_PWM:   w_led_nxt[c] = (w_cnt_nxt[c] < w_duty_nxt[c]);
                default:    w_led_nxt[c] = 1'b0;
            endcase
        end
    end

    always_comb begin
        w_rdata = '0;
        if (i_addr == ADDR_W'(0))
            w_rdata[PRE_W-1:0] = r_prescale;
        if (i_addr == ADDR_W'(1))
            w_rdata[0] = r_en;
        for (int c = 0; c < NCHAN; c++) begin
            if (i_addr == ADDR_W'(2 + 2 * c)) begin
                w_rdata[1:0]       = r_mode[c];
                w_rdata[8 +: CNT_W] = r_per[c];
            end
            if (i_addr == ADDR_W'(3 + 2 * c))
                w_rdata[CNT_W-1:0] = r_duty[c];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_prescale <= '0;
            r_pcnt     <= '0;
            r_en       <= 1'b0;
            r_ph       <= '0;
            r_led      <= '0;
            r_dout     <= '0;
            for (int c = 0; c < NCHAN; c++) begin
                r_mode[c] <= MODE_OFF;
                r_per[c]  <= '0;
                r_duty[c] <= '0;
                r_cnt[c]  <= '0;
            end
        end else begin
            if (w_wr_pre)
                r_prescale <= i_din[PRE_W-1:0];
            if (w_wr_ctrl)
                r_en <= i_din[0];
            if (!r_en || w_wr_pre || w_restart || w_tick)
                r_pcnt <= '0;
            else
                r_pcnt <= r_pcnt + PRE_W'(1);
            if (i_rd)
                r_dout <= w_rdata;
            r_ph  <= w_ph_nxt;
            r_led <= w_led_nxt;
            for (int c = 0; c < NCHAN; c++) begin
                r_mode[c] <= w_mode_nxt[c];
                r_per[c]  <= w_per_nxt[c];
                r_duty[c] <= w_duty_nxt[c];
                r_cnt[c]  <= w_cnt_nxt[c];
            end
        end
    end

    assign o_dout = r_dout;
    assign o_tick = w_tick;
    assign o_led  = r_led;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Bench for led_pattern_ctrl: directed + random bus traffic,
// reference model pushes per-cycle expectations, monitor compares.
module tb_led_pattern_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  addr = '0;
    logic [15:0] din = '0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [15:0] dout;
    logic        tick;
    logic [7:0]  led;

    always #5 clk = ~clk;

    led_pattern_ctrl dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_addr  (addr),
        .i_din   (din),
        .i_wr    (wr),
        .i_rd    (rd),
        .o_dout  (dout),
        .o_tick  (tick),
        .o_led   (led)
    );

    typedef struct {
        logic        tick;
        logic [7:0]  led;
        logic [15:0] dout;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int passed = 0;

    // Reference model: channel state is "ticks since last clear".
    bit          m_en;
    int          m_pre;
    int          m_pcyc;
    int          m_mode [8];
    int          m_per  [8];
    int          m_duty [8];
    int          m_tk   [8];
    logic [7:0]  m_led;
    logic [15:0] m_dout;

    function automatic bit m_tick();
        return m_en && ((m_pcyc % (m_pre + 1)) == m_pre);
    endfunction

    function automatic logic [15:0] m_read(input int a);
        int c;
        if (a == 0) return 16'(m_pre);
        if (a == 1) return {15'd0, m_en};
        if (a >= 2 && a < 18) begin
            c = (a - 2) / 2;
            if (a % 2 == 0) return 16'((m_per[c] << 8) | m_mode[c]);
            return 16'(m_duty[c]);
        end
        return 16'd0;
    endfunction

    function automatic bit m_led_of(input int c);
        case (m_mode[c])
            0: return 1'b0;
            1: return 1'b1;
            2: return ((m_tk[c] / (m_per[c] + 1)) % 2) == 1;
            default: return (m_tk[c] % (m_per[c] + 1)) < m_duty[c];
        endcase
    endfunction

    task automatic m_clear();
        m_en = 0; m_pre = 0; m_pcyc = 0; m_led = '0; m_dout = '0;
        for (int c = 0; c < 8; c++) begin
            m_mode[c] = 0; m_per[c] = 0; m_duty[c] = 0; m_tk[c] = 0;
        end
    endtask

    task automatic m_step(input bit r, input int a, input int d,
                          input bit w, input bit rr);
        bit t;
        bit rs;
        if (r) begin
            m_clear();
            return;
        end
        t  = m_tick();
        rs = w && (a == 1) && d[1];
        if (rr) m_dout = m_read(a);
        if (!m_en || rs || (w && a == 0)) m_pcyc = 0;
        else m_pcyc++;
        for (int c = 0; c < 8; c++) begin
            if ((w && (a == 2 + 2 * c || a == 3 + 2 * c)) || rs) m_tk[c] = 0;
            else if (t) m_tk[c]++;
            if (w && a == 2 + 2 * c) begin
                m_mode[c] = d & 3;
                m_per[c]  = (d >> 8) & 255;
            end
            if (w && a == 3 + 2 * c) m_duty[c] = d & 255;
        end
        if (w && a == 0) m_pre = d & 16'hffff;
        if (w && a == 1) m_en = d[0];
        for (int c = 0; c < 8; c++) m_led[c] = m_led_of(c);
    endtask

    task automatic cyc(input bit r, input int a, input int d,
                       input bit w, input bit rr);
        exp_t e;
        @(posedge clk);
        #1;
        reset = r; addr = a[4:0]; din = d[15:0]; wr = w; rd = rr;
        e.tick = m_tick();
        e.led  = m_led;
        e.dout = m_dout;
        q.push_back(e);
        m_step(r, a, d, w, rr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic chk(input string n, input logic [15:0] got,
                       input logic [15:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h want %h at %0t", n, got, want, $time);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("tick", {15'd0, tick}, {15'd0, e.tick});
            chk("led", {8'd0, led}, {8'd0, e.led});
            chk("dout", dout, e.dout);
        end
    end

    initial begin
        int a;
        int d;
        m_clear();
        cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        cyc(0, 2, 0, 0, 1);
        idle(6);
        // prescaler 1 in 4, then disabled
        cyc(0, 0, 3, 1, 0);
        cyc(0, 1, 1, 1, 0);
        idle(16);
        cyc(0, 1, 0, 1, 0);
        idle(8);
        // blink on channel 0 at full rate
        cyc(0, 0, 0, 1, 0);
        cyc(0, 1, 1, 1, 0);
        cyc(0, 2, 16'h0202, 1, 0);
        idle(12);
        // pwm on channel 1: duty 1, 0, above period
        cyc(0, 4, 16'h0303, 1, 0);
        cyc(0, 5, 1, 1, 0);
        idle(12);
        cyc(0, 5, 0, 1, 0);
        idle(8);
        cyc(0, 5, 5, 1, 0);
        idle(8);
        // two blink channels out of phase, then restart
        cyc(0, 6, 16'h0402, 1, 0);
        idle(3);
        cyc(0, 8, 16'h0402, 1, 0);
        idle(5);
        cyc(0, 1, 3, 1, 0);
        idle(20);
        for (int i = 0; i < 22; i++) cyc(0, i, 0, 0, 1);
        // reset mid-pwm with a simultaneous write, then readback
        cyc(1, 4, 16'h0503, 1, 0);
        cyc(0, 4, 0, 0, 1);
        cyc(0, 5, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);
        idle(4);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            a = $urandom_range(0, 31);
            case (a)
                0: d = $urandom_range(0, 3);
                1: d = ($urandom_range(0, 9) < 8 ? 1 : 0)
                       | ($urandom_range(0, 9) == 0 ? 2 : 0);
                default:
                    if (a < 18 && a % 2 == 0)
                        d = ($urandom_range(0, 5) << 8) | ($urandom & 16'hff);
                    else if (a < 18)
                        d = ($urandom & 16'hff00) | $urandom_range(0, 7);
                    else
                        d = $urandom & 16'hffff;
            endcase
            cyc($urandom_range(0, 199) == 0, a, d,
                $urandom_range(0, 99) < 15, $urandom_range(0, 1) == 1);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending want 0", q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
